// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler control unit: opcodes, ALU select codes,
// control-word bit positions and the packed 13-bit control word.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0,
    OP_JNC  = 4'h1,
    OP_CMPI = 4'h2,
    OP_CMPM = 4'h3,
    OP_LIT  = 4'h4,
    OP_IN   = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_ADDI = 4'hA,
    OP_ADDM = 4'hB,
    OP_JMP  = 4'hC,
    OP_OUT  = 4'hD,
    OP_NORI = 4'hE,
    OP_NORM = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_PASS_B = 3'b010,
    ALU_ADD    = 3'b011,
    ALU_NOR    = 3'b100
  } alu_sel_t;

  localparam int CW_WIDTH        = 13;
  localparam int BIT_INC_PC      = 12;
  localparam int BIT_LOAD_PC     = 11;
  localparam int BIT_LOAD_A      = 10;
  localparam int BIT_LOAD_FLAGS  = 9;
  localparam int BIT_S_HI        = 8;
  localparam int BIT_S_LO        = 6;
  localparam int BIT_CS_RAM      = 5;
  localparam int BIT_WE_RAM      = 4;
  localparam int BIT_OE_ALU      = 3;
  localparam int BIT_OE_IN       = 2;
  localparam int BIT_OE_OPERAND  = 1;
  localparam int BIT_LOAD_OUT    = 0;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic     inc_pc;
    logic     load_pc;
    logic     load_a;
    logic     load_flags;
    alu_sel_t s;
    logic     cs_ram;
    logic     we_ram;
    logic     oe_alu;
    logic     oe_in;
    logic     oe_operand;
    logic     load_out;
  } ctrl_word_t;

  // Conditional jump: take the branch, or step PC past the operand.
  function automatic ctrl_word_t jump_if(input logic cond);
    ctrl_word_t cw;
    cw         = '0;
    cw.load_pc = cond;
    cw.inc_pc  = ~cond;
    return cw;
  endfunction

endpackage

// File: rtl/nibbler_control_unit_if.sv
// Decoder inputs from fetch/ALU and the control word / flags it returns.
interface nibbler_control_unit_if;
  import nibbler_pkg::*;

  logic                phase;
  logic [3:0]          instr;
  logic                zero;
  logic                c_out;
  logic                phase_out;
  logic                zero_out;
  logic                c_out_out;
  logic [CW_WIDTH-1:0] out_data;

  modport master (
    output phase, instr, zero, c_out,
    input  phase_out, zero_out, c_out_out, out_data
  );

  modport slave (
    input  phase, instr, zero, c_out,
    output phase_out, zero_out, c_out_out, out_data
  );
endinterface

// File: rtl/nibbler_flag_reg.sv
// Two enabled flip-flops with asynchronous active-low clear; holds the
// Z (bit 1) and C (bit 0) flags of the Nibbler CPU.
module nibbler_flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] d,
  output logic [1:0] q
);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_flag
    logic q_reg;

    // Capture the ALU flag only when the control word asks for it.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        q_reg <= 1'b0;
      else if (en)
        q_reg <= d[gi];
    end

    assign q[gi] = q_reg;
  end

endmodule

// File: rtl/nibbler_control_unit.sv
// Nibbler CPU control unit: combinational two-phase microcode decoder
// addressed by {phase, opcode, C, Z} plus the flag register it feeds.
// Optional build macro PHASE_GEN_EN: generate the fetch/execute phase
// internally with a toggling flip-flop instead of using the phase input.
module nibbler_control_unit
  import nibbler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  nibbler_control_unit_if.slave  bus
);

  logic       eff_phase;
  opcode_t    op;
  ctrl_word_t cw;
  logic [1:0] flags_q;
  logic       c_flag;
  logic       z_flag;

`ifdef PHASE_GEN_EN
  logic phase_reg;

  // Free-running fetch/execute alternation starting at fetch after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      phase_reg <= 1'b0;
    else
      phase_reg <= ~phase_reg;
  end

  assign eff_phase = phase_reg;
`else
  assign eff_phase = bus.phase;
`endif

  assign op     = opcode_t'(bus.instr);
  assign z_flag = flags_q[1];
  assign c_flag = flags_q[0];

  // Microcode: fetch always steps PC; execute decodes opcode and flags.
  always_comb begin
    cw = '0;
    if (!eff_phase) begin
      cw.inc_pc = 1'b1;
    end else begin
      case (op)
        OP_JC:   cw = jump_if(c_flag);
        OP_JNC:  cw = jump_if(~c_flag);
        OP_JZ:   cw = jump_if(z_flag);
        OP_JNZ:  cw = jump_if(~z_flag);
        OP_JMP:  cw.load_pc = 1'b1;
        OP_CMPI, OP_CMPM: begin
          cw.inc_pc     = 1'b1;
          cw.load_flags = 1'b1;
          cw.s          = ALU_SUB;
          cw.oe_operand = (op == OP_CMPI);
          cw.cs_ram     = (op == OP_CMPM);
        end
        OP_LIT, OP_IN, OP_LD: begin
          cw.inc_pc     = 1'b1;
          cw.load_a     = 1'b1;
          cw.s          = ALU_PASS_B;
          cw.oe_operand = (op == OP_LIT);
          cw.oe_in      = (op == OP_IN);
          cw.cs_ram     = (op == OP_LD);
        end
        OP_ST: begin
          cw.inc_pc = 1'b1;
          cw.s      = ALU_PASS_A;
          cw.cs_ram = 1'b1;
          cw.we_ram = 1'b1;
          cw.oe_alu = 1'b1;
        end
        OP_ADDI, OP_ADDM: begin
          cw.inc_pc     = 1'b1;
          cw.load_a     = 1'b1;
          cw.load_flags = 1'b1;
          cw.s          = ALU_ADD;
          cw.oe_operand = (op == OP_ADDI);
          cw.cs_ram     = (op == OP_ADDM);
        end
        OP_OUT: begin
          cw.inc_pc   = 1'b1;
          cw.s        = ALU_PASS_A;
          cw.oe_alu   = 1'b1;
          cw.load_out = 1'b1;
        end
        OP_NORI, OP_NORM: begin
          cw.inc_pc     = 1'b1;
          cw.load_a     = 1'b1;
          cw.load_flags = 1'b1;
          cw.s          = ALU_NOR;
          cw.oe_operand = (op == OP_NORI);
          cw.cs_ram     = (op == OP_NORM);
        end
        default: cw = '0;
      endcase
    end
  end

  assign bus.out_data  = cw;
  assign bus.phase_out = eff_phase;
  assign bus.zero_out  = z_flag;
  assign bus.c_out_out = c_flag;

  nibbler_flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .en    (bus.out_data[BIT_LOAD_FLAGS]),
    .d     ({bus.zero, bus.c_out}),
    .q     (flags_q)
  );

endmodule

// File: tb/tb_nibbler_control_unit.sv
// Self-checking bench for nibbler_control_unit: directed vectors, a full
// decode sweep and randomized execute cycles against a behavioural model.
module tb_nibbler_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nibbler_control_unit_if bus ();

  nibbler_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model flags as the bench believes them to be.
  bit mc = 1'b0;
  bit mz = 1'b0;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  // Reference decoder written straight from the opcode table.
  function automatic logic [12:0] model(input bit ph, input logic [3:0] op, input bit c, input bit z);
    logic [12:0] take, skip;
    take = 13'h0800;
    skip = 13'h1000;
    if (!ph) return 13'h1000;
    case (op)
      4'h0: return c  ? take : skip;
      4'h1: return !c ? take : skip;
      4'h2: return 13'h1242;
      4'h3: return 13'h1260;
      4'h4: return 13'h1482;
      4'h5: return 13'h1484;
      4'h6: return 13'h14A0;
      4'h7: return 13'h1038;
      4'h8: return z  ? take : skip;
      4'h9: return !z ? take : skip;
      4'hA: return 13'h16C2;
      4'hB: return 13'h16E0;
      4'hC: return 13'h0800;
      4'hD: return 13'h1009;
      4'hE: return 13'h1702;
      default: return 13'h1720;
    endcase
  endfunction

  // Opcodes whose execute cycle writes the flags.
  function automatic bit writes_flags(input logic [3:0] op);
    return (op == 4'h2) || (op == 4'h3) || (op == 4'hA) || (op == 4'hB) ||
           (op == 4'hE) || (op == 4'hF);
  endfunction

  // Load flags through an ADDI execute cycle (only valid without phase gen).
  task automatic set_flags(input bit c, input bit z);
    bus.phase = 1'b1;
    bus.instr = 4'hA;
    bus.zero  = z;
    bus.c_out = c;
    @(posedge clk);
    #1;
    mc = c;
    mz = z;
    check("set_flags", {11'd0, bus.zero_out, bus.c_out_out}, {11'd0, z, c});
  endtask

  typedef struct {
    string      name;
    bit         ph;
    logic [3:0] instr;
    bit         c;
    bit         z;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"fetch_any",  1'b0, 4'h7, 1'b1, 1'b1, 13'h1000};
    vecs[1] = '{"jc_c0",      1'b1, 4'h0, 1'b0, 1'b0, 13'h1000};
    vecs[2] = '{"jc_c1",      1'b1, 4'h0, 1'b1, 1'b0, 13'h0800};
    vecs[3] = '{"jnz_z0",     1'b1, 4'h9, 1'b0, 1'b0, 13'h0800};
    vecs[4] = '{"jnz_z1",     1'b1, 4'h9, 1'b0, 1'b1, 13'h1000};
    vecs[5] = '{"lit",        1'b1, 4'h4, 1'b1, 1'b0, 13'h1482};
    vecs[6] = '{"addi",       1'b1, 4'hA, 1'b0, 1'b1, 13'h16C2};
    vecs[7] = '{"jmp",        1'b1, 4'hC, 1'b1, 1'b1, 13'h0800};

    // Reset held low with every flag source active.
    reset     = 1'b0;
    bus.phase = 1'b1;
    bus.instr = 4'hA;
    bus.zero  = 1'b1;
    bus.c_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {11'd0, bus.zero_out, bus.c_out_out}, 13'd0);
    check("rst_decode_addi", bus.out_data, 13'h16C2);
`ifdef PHASE_GEN_EN
    check("rst_phase", {12'd0, bus.phase_out}, 13'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("phase_edge%0d", i), {12'd0, bus.phase_out}, (i % 2 == 0) ? 13'd1 : 13'd0);
      check($sformatf("gen_decode%0d", i), bus.out_data,
            model(bus.phase_out, bus.instr, bus.c_out_out, bus.zero_out));
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("phase_async_clear", {12'd0, bus.phase_out}, 13'd0);
    check("flags_async_clear", {11'd0, bus.zero_out, bus.c_out_out}, 13'd0);
`else
    bus.phase = 1'b0;
    #1;
    check("rst_fetch", bus.out_data, 13'h1000);
    check("phase_pass0", {12'd0, bus.phase_out}, 13'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mc = 1'b0;
    mz = 1'b0;
    bus.phase = 1'b1;
    #1;
    check("phase_pass1", {12'd0, bus.phase_out}, 13'd1);

    // Directed vectors: preload flags, then decode combinationally.
    for (int i = 0; i < 8; i++) begin
      set_flags(vecs[i].c, vecs[i].z);
      bus.phase = vecs[i].ph;
      bus.instr = vecs[i].instr;
      #1;
      check(vecs[i].name, bus.out_data, vecs[i].exp);
    end

    // ADDI captures flags at the edge; word is visible beforehand.
    set_flags(1'b0, 1'b0);
    bus.instr = 4'hA;
    bus.zero  = 1'b1;
    bus.c_out = 1'b1;
    #1;
    check("addi_before_edge", bus.out_data, 13'h16C2);
    @(posedge clk);
    #1;
    check("addi_flags_after", {11'd0, bus.zero_out, bus.c_out_out}, 13'd3);

    // LIT must not disturb the flags.
    set_flags(1'b0, 1'b0);
    bus.instr = 4'h4;
    bus.zero  = 1'b1;
    bus.c_out = 1'b1;
    #1;
    check("lit_word", bus.out_data, 13'h1482);
    @(posedge clk);
    #1;
    check("lit_flags_hold", {11'd0, bus.zero_out, bus.c_out_out}, 13'd0);

    // Exhaustive decode sweep; ALU inputs mirror the flags so any
    // incidental edge during a flag-writing opcode reloads the same values.
    for (int f = 0; f < 4; f++) begin
      set_flags(f[0], f[1]);
      for (int ph = 0; ph < 2; ph++) begin
        for (int op = 0; op < 16; op++) begin
          bus.phase = ph[0];
          bus.instr = op[3:0];
          bus.zero  = f[1];
          bus.c_out = f[0];
          #1;
          check($sformatf("sweep_p%0d_op%0h_c%0d_z%0d", ph, op, f[0], f[1]),
                bus.out_data, model(ph[0], op[3:0], f[0], f[1]));
        end
      end
    end

    // Randomized cycles: the model updates flags on flag-writing opcodes.
    @(posedge clk);
    #1;
    mc = bus.c_out_out;
    mz = bus.zero_out;
    for (int n = 0; n < 150; n++) begin
      bit       ph, z, c;
      logic [3:0] op;
      ph = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      z  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      bus.phase = ph;
      bus.instr = op;
      bus.zero  = z;
      bus.c_out = c;
      #1;
      check($sformatf("rand%0d_word", n), bus.out_data, model(ph, op, mc, mz));
      if (ph && writes_flags(op)) begin
        mz = z;
        mc = c;
      end
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_flags", n), {11'd0, bus.zero_out, bus.c_out_out}, {11'd0, mz, mc});
    end

    // Asynchronous clear between clock edges.
    set_flags(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("flags_async_clear", {11'd0, bus.zero_out, bus.c_out_out}, 13'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
